// File: rtl/ft245_rx_cmd.sv
// FT245 sync-FIFO receive path: reads host bytes and frames them into addr/data commands.
// Define FT_RX_CKSUM_EN for a 5-byte frame with XOR checksum; otherwise frames are 4 bytes.
module ft245_rx_cmd #(
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        ft_shift_clk,
    input  logic        rst,
    input  logic        ft_rxf_i,
    input  logic [7:0]  ft_adbus_i,
    input  logic        tx_active_i,
    output logic        ft_oe_o,
    output logic        ft_rd_o,
    output logic        ft_bus_busy_o,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StOe, StRead} state_e;

    state_e      state_q, state_d;
    logic        oe_d, rd_d, busy_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  hi_q, hi_d;
`ifdef FT_RX_CKSUM_EN
    logic [7:0]  lo_q, lo_d;
`endif
    logic [7:0]  tmo_q, tmo_d;
    logic        cmd_valid_d;
    logic [7:0]  cmd_addr_d;
    logic [15:0] cmd_data_d;
    logic [7:0]  err_d;
    logic        accept, frame_done, frame_err, tmo_fire;

    assign accept = (state_q == StRead) && !ft_rd_o && !ft_rxf_i;

    // Byte parser, inter-byte timeout and command register.
    always_comb begin
        idx_d      = idx_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
`ifdef FT_RX_CKSUM_EN
        lo_d       = lo_q;
`endif
        frame_done = 1'b0;
        frame_err  = 1'b0;
        tmo_fire   = 1'b0;
        tmo_d      = tmo_q;
        cmd_addr_d = cmd_addr;
        cmd_data_d = cmd_data;
        if (accept) begin
            case (idx_q)
                3'd0: if (ft_adbus_i == HDR_BYTE) idx_d = 3'd1;
                3'd1: begin
                    addr_d = ft_adbus_i;
                    idx_d  = 3'd2;
                end
                3'd2: begin
                    hi_d  = ft_adbus_i;
                    idx_d = 3'd3;
                end
`ifdef FT_RX_CKSUM_EN
                3'd3: begin
                    lo_d  = ft_adbus_i;
                    idx_d = 3'd4;
                end
                default: begin
                    idx_d = 3'd0;
                    if (ft_adbus_i == (addr_q ^ hi_q ^ lo_q)) begin
                        frame_done = 1'b1;
                        cmd_addr_d = addr_q;
                        cmd_data_d = {hi_q, lo_q};
                    end else begin
                        frame_err = 1'b1;
                    end
                end
`else
                default: begin
                    idx_d      = 3'd0;
                    frame_done = 1'b1;
                    cmd_addr_d = addr_q;
                    cmd_data_d = {hi_q, ft_adbus_i};
                end
`endif
            endcase
        end

        // An accepted byte always wins over an expiring timeout.
        if (accept || idx_q == 3'd0) begin
            tmo_d = 8'd0;
        end else if (tmo_q >= TmoLast) begin
            tmo_fire = 1'b1;
            tmo_d    = 8'd0;
            idx_d    = 3'd0;
        end else begin
            tmo_d = tmo_q + 8'd1;
        end

        err_d = err_cnt;
        if ((frame_err || tmo_fire) && err_cnt != 8'hFF) err_d = err_cnt + 8'd1;

        cmd_valid_d = cmd_valid;
        if (frame_done) begin
            cmd_valid_d = 1'b1;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    // Bus FSM; strobes are registered and change together with the state.
    always_comb begin
        state_d = state_q;
        oe_d    = ft_oe_o;
        rd_d    = ft_rd_o;
        busy_d  = ft_bus_busy_o;
        unique case (state_q)
            StIdle: begin
                if (!ft_rxf_i && !tx_active_i && !cmd_valid) begin
                    state_d = StOe;
                    oe_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StOe: begin
                state_d = StRead;
                rd_d    = 1'b0;
            end
            StRead: begin
                if (ft_rxf_i || frame_done) begin
                    state_d = StIdle;
                    oe_d    = 1'b1;
                    rd_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                oe_d    = 1'b1;
                rd_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ft_shift_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            ft_oe_o       <= 1'b1;
            ft_rd_o       <= 1'b1;
            ft_bus_busy_o <= 1'b0;
            idx_q         <= 3'd0;
            addr_q        <= 8'd0;
            hi_q          <= 8'd0;
`ifdef FT_RX_CKSUM_EN
            lo_q          <= 8'd0;
`endif
            tmo_q         <= 8'd0;
            cmd_valid     <= 1'b0;
            cmd_addr      <= 8'd0;
            cmd_data      <= 16'd0;
            err_cnt       <= 8'd0;
        end else begin
            state_q       <= state_d;
            ft_oe_o       <= oe_d;
            ft_rd_o       <= rd_d;
            ft_bus_busy_o <= busy_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            hi_q          <= hi_d;
`ifdef FT_RX_CKSUM_EN
            lo_q          <= lo_d;
`endif
            tmo_q         <= tmo_d;
            cmd_valid     <= cmd_valid_d;
            cmd_addr      <= cmd_addr_d;
            cmd_data      <= cmd_data_d;
            err_cnt       <= err_d;
        end
    end

endmodule

// File: tb/tb_ft245_rx_cmd.sv
// Scoreboard bench for ft245_rx_cmd: FT245 FIFO model, frame-level reference model, monitor.
module tb_ft245_rx_cmd;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int T = 24;
`ifdef FT_RX_CKSUM_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ft_rxf;
    logic [7:0]  ft_adbus;
    logic        tx_active;
    logic        ft_oe, ft_rd, ft_busy;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int         ft_q[$];   // 0..255: byte; 256+g: RXF# held high for about g clocks
    int         pop_cnt    = 0;
    int         ready_mode = 1;  // 0: low, 1: high, 2: random
    cmd_t       exp_q[$];
    logic [7:0] m_buf[$];
    int         exp_err    = 0;

    ft245_rx_cmd #(
        .HDR_BYTE(HDR),
        .TIMEOUT (T)
    ) dut (
        .ft_shift_clk (clk),
        .rst          (rst),
        .ft_rxf_i     (ft_rxf),
        .ft_adbus_i   (ft_adbus),
        .tx_active_i  (tx_active),
        .ft_oe_o      (ft_oe),
        .ft_rd_o      (ft_rd),
        .ft_bus_busy_o(ft_busy),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .err_cnt      (err_cnt)
    );

    always #8 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    // Reference model: collect a frame starting at a header; judge it once N bytes are in.
    task automatic model_byte(input logic [7:0] b);
        if (m_buf.size() == 0 && b != HDR) return;
        m_buf.push_back(b);
        if (m_buf.size() == N) begin
`ifdef FT_RX_CKSUM_EN
            if ((m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[4])
                exp_q.push_back({m_buf[1], m_buf[2], m_buf[3]});
            else
                bump_err();
`else
            exp_q.push_back({m_buf[1], m_buf[2], m_buf[3]});
`endif
            m_buf.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ft_q.push_back(int'(b));
        model_byte(b);
    endtask

    task automatic send_gap(input int g);
        ft_q.push_back(256 + g);
        if (g >= T && m_buf.size() != 0) begin
            bump_err();
            m_buf.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                              input bit bad, input int gap_at);
        logic [7:0] f[$];
        f.push_back(HDR);
        f.push_back(a);
        f.push_back(hi);
        f.push_back(lo);
`ifdef FT_RX_CKSUM_EN
        f.push_back(a ^ hi ^ lo ^ {7'd0, bad});
`else
        if (bad) f.push_back(8'h00);
`endif
        foreach (f[i]) begin
            if (i == gap_at) send_gap(2 + int'($urandom_range(0, 2)));
            send_byte(f[i]);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while ((ft_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(n < max_cyc), 32'd1);
        repeat (T + 6) @(posedge clk);
        #3;
        check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // FT245 FIFO model: pops the head byte on every edge where RD# and RXF# were both low.
    initial begin : ft_model
        logic take;
        ft_rxf   = 1'b1;
        ft_adbus = 8'h00;
        forever begin
            @(negedge clk);
            take = !ft_rd && !ft_rxf;
            @(posedge clk);
            #1;
            if (take && ft_q.size() > 0) begin
                void'(ft_q.pop_front());
                pop_cnt++;
            end
            if (ft_q.size() > 0 && ft_q[0] >= 256) begin
                ft_q[0] = ft_q[0] - 1;
                if (ft_q[0] <= 256) void'(ft_q.pop_front());
            end
            if (ft_q.size() > 0 && ft_q[0] < 256) begin
                ft_rxf   = 1'b0;
                ft_adbus = 8'(ft_q[0]);
            end else begin
                ft_rxf = 1'b1;
            end
        end
    end

    initial begin : ready_drv
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold-stability while stalled.
    initial begin : monitor
        logic stall;
        cmd_t held, got, exp;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                got = {cmd_addr, cmd_data};
                if (stall) check("hold_stable", {7'd0, cmd_valid, got}, {8'd1, held});
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", 32'(got), 32'hFFFFFFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("cmd_addr_data", 32'(got), 32'(exp));
                    end
                end
                stall = cmd_valid && !cmd_ready;
                held  = got;
            end
        end
    end

    initial begin : watchdog
        #(60000 * 16);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, base, t1, t2, c;
        logic pv, rd_low_seen;
        rst       = 1'b1;
        tx_active = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe", 32'(ft_oe), 32'd1);
        check("rst_rd", 32'(ft_rd), 32'd1);
        check("rst_busy", 32'(ft_busy), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_data", 32'(cmd_data), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        // Good frame with strobe timing
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, -1);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (ft_rxf && n < 10);
        @(posedge clk);
        #1;
        check("oe_after_rxf", {29'd0, ft_oe, ft_rd, ft_busy}, 32'b011);
        @(posedge clk);
        #1;
        check("rd_after_oe", 32'(ft_rd), 32'd0);
        repeat (N - 1) @(posedge clk);
        #1;
        check("valid_early", 32'(cmd_valid), 32'd0);
        @(posedge clk);
        #1;
        check("valid_on_last", 32'(cmd_valid), 32'd1);
        wait_idle("good", 500);

        // Bad checksum followed by good frame
        send_frame(8'h12, 8'h34, 8'h56, 1'b1, -1);
        send_frame(8'h01, 8'h00, 8'hFF, 1'b0, -1);
        wait_idle("bad_good", 500);

        // Command-to-command spacing with ready high
        send_frame(8'h21, 8'h43, 8'h65, 1'b0, -1);
        send_frame(8'h87, 8'hA9, 8'hCB, 1'b0, -1);
        c  = 0;
        t1 = -1;
        t2 = -1;
        pv = 1'b0;
        while (t2 < 0 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (cmd_valid && !pv) begin
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
            pv = cmd_valid;
        end
        check("cmd_spacing", 32'(t2 - t1), 32'(N + 3));
        wait_idle("spacing", 500);

        // Back-pressure: two frames, consumer stalled for 50 clocks
        ready_mode = 0;
        base = pop_cnt;
        send_frame(8'h5A, 8'h11, 8'h22, 1'b0, -1);
        send_frame(8'hC3, 8'h33, 8'h44, 1'b0, -1);
        rd_low_seen = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (cmd_valid && !ft_rd) rd_low_seen = 1'b1;
        end
        check("bp_bytes", 32'(pop_cnt - base), 32'(N));
        check("bp_rd_low", 32'(rd_low_seen), 32'd0);
        check("bp_state", {29'd0, cmd_valid, ft_rd, ft_busy}, 32'b110);
        ready_mode = 1;
        wait_idle("backpressure", 500);

        // Resync garbage, partial frame, timeout, then a clean frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(HDR);
        send_byte(8'h12);
        send_gap(T + 8);
        send_frame(8'h9E, 8'hBE, 8'hEF, 1'b0, -1);
        wait_idle("resync", 800);

        // Arbitration with the transmit path
        tx_active = 1'b1;
        base = pop_cnt;
        send_frame(8'h44, 8'h55, 8'h66, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        check("arb_hold", {29'd0, ft_oe, ft_rd, ft_busy}, 32'b110);
        check("arb_bytes", 32'(pop_cnt - base), 32'd0);
        tx_active = 1'b0;
        @(posedge clk);
        #1;
        check("arb_start", {30'd0, ft_oe, ft_busy}, 32'b01);
        wait_idle("arb", 500);

        // Randomised traffic with random consumer stalls
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : -1);
            end else if (r < 8) begin
                send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, -1);
            end else begin
                repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
            end
        end
        send_gap(T + 8);
        wait_idle("random", 6000);
        ready_mode = 1;

        // Saturate err_cnt with timeouts, then one more error at the ceiling
        n = (exp_err < 250) ? 260 - exp_err : 10;
        for (int k = 0; k < n; k++) begin
            send_byte(HDR);
            send_gap(T + 8);
        end
        send_frame(8'h01, 8'h02, 8'h03, 1'b1, -1);
        send_gap(T + 8);
        wait_idle("saturate", 20000);

        // Reset in mid-frame; stale bytes must not merge with the next frame
        base = pop_cnt;
        ft_q.push_back(int'(HDR));
        ft_q.push_back(32'h77);
        ft_q.push_back(32'h88);
        ft_q.push_back(32'h99);
        n = 0;
        while (pop_cnt < base + 2 && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("mid_bytes", 32'(n < 50), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_bus", {29'd0, ft_oe, ft_rd, ft_busy}, 32'b110);
        check("mid_rst_cmd", {7'd0, cmd_valid, cmd_addr, cmd_data}, 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        ft_q.delete();
        exp_q.delete();
        m_buf.delete();
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #3;
        send_frame(8'h3C, 8'h5A, 8'hC3, 1'b0, -1);
        wait_idle("post_rst", 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ft245_rx_cmd.md
# ft245_rx_cmd

- Host-to-device receive path of the FT245 synchronous-FIFO USB link; runs in the `ft_shift_clk` domain, opposite in direction to the ADC→FIFO→`ft_adbus_o` transmit path.
- Drives the FT245 read strobes and samples bytes from the data bus.
- Frames the bytes into host commands: header, address, 16-bit data and checksum.
- Presents each command with a valid/ready handshake to the register/control logic.

## Interface

Parameters:

- `HDR_BYTE`, `8'hA5`: frame start byte.
- `TIMEOUT`, `255`: inter-byte timeout in clocks (1..255); an incomplete frame is abandoned after it expires.

Ports:

- `ft_shift_clk`, input, 1: FT245 CLKOUT (60 MHz); the only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `ft_rxf_i`, input, 1: FT245 RXF#, active-low, "receive data available".
- `ft_adbus_i`, input, 8: FT245 data bus, read direction.
- `tx_active_i`, input, 1: transmit path currently owns the bus.
- `ft_oe_o`, output, 1: FT245 OE#, active-low.
- `ft_rd_o`, output, 1: FT245 RD#, active-low.
- `ft_bus_busy_o`, output, 1: receiver owns the bus; the transmit path must hold off.
- `cmd_valid`, output, 1: command available.
- `cmd_ready`, input, 1: consumer accepts the command.
- `cmd_addr`, output, 8: command register address.
- `cmd_data`, output, 16: command data, `{data_hi, data_lo}`.
- `err_cnt`, output, 8: saturating count of framing errors.

## Operation

- **Registered outputs.** All outputs are registered. Reset values:
  - `ft_oe_o=1`, `ft_rd_o=1`
  - `ft_bus_busy_o=0`, `cmd_valid=0`
  - `cmd_addr=0`, `cmd_data=0`, `err_cnt=0`
- **Bus FSM states:** IDLE, OE, READ.
  - **IDLE → OE** when `ft_rxf_i==0 && !tx_active_i && !cmd_valid`.
    - Sets `ft_oe_o=0` and `ft_bus_busy_o=1`.
  - **OE → READ** unconditionally after one cycle (bus turnaround). Sets `ft_rd_o=0`.
  - **READ:** a byte is accepted on every rising edge where the registered `ft_rd_o==0` and `ft_rxf_i==0`.
  - **READ → IDLE** on either of:
    - `ft_rxf_i==1` sampled;
    - the accepted byte completes a frame (`cmd_valid` set on that same edge).
  - Leaving READ deasserts `ft_oe_o`, `ft_rd_o` and `ft_bus_busy_o` on the same edge, so no byte beyond the frame is consumed.
  - `tx_active_i` is ignored once OE is entered; the burst runs to completion.
- **Parser.** Byte index `idx` runs 0..N-1, where N=5 (see Configuration).
  - **idx 0:** the byte must equal `HDR_BYTE`. Any other byte is silently skipped; this is resync and does not count as an error.
  - **idx 1:** address.
  - **idx 2:** data high byte.
  - **idx 3:** data low byte.
  - **idx 4:** checksum, equal to `addr ^ data_hi ^ data_lo`.
  - **Good frame:** loads `cmd_addr`/`cmd_data`, sets `cmd_valid=1`, `idx→0`.
  - **Checksum mismatch:** drops the frame, `err_cnt+1`, `idx→0`.
- **Timeout.**
  - A counter is cleared on every accepted byte and increments each clock while `idx!=0`.
  - On reaching `TIMEOUT`: `idx→0`, `err_cnt+1`.
  - The counter is held at 0 while `idx==0`.
- **`err_cnt` saturation.** Saturates at 255; it never wraps.
- **Handshake.**
  - `cmd_valid`, `cmd_addr` and `cmd_data` hold stable until the edge where `cmd_valid && cmd_ready`; `cmd_valid` then clears.
  - No new burst starts while `cmd_valid==1`.
  - Consumer stall therefore throttles the host via FT245 RXF#; no data is lost.
- **Reset mid-operation.** Asserting `rst` immediately returns all outputs to their reset values, discards any partial frame and returns the FSM to IDLE.

## Timing

- **RXF#-low to OE#-low:** 1 clock. OE# low to RD# low: 1 clock.
- **First byte** is sampled on the edge after RD# goes low.
- **Sustained rate:** 1 byte per clock while RXF# is low.
- **Frame latency:** `cmd_valid` rises on the same edge that samples the last frame byte.
- **Acceptance:** `cmd_valid && cmd_ready` clears `cmd_valid` on the next edge.
- **Earliest next burst:** IDLE→OE on that same edge if RXF# is still low. Minimum command-to-command spacing with `cmd_ready` tied high: N+3 clocks.
- **RXF# high in mid-frame:**
  - RD#/OE# release on the following edge.
  - `idx` is retained, and the frame resumes on the next burst unless the timeout expires first.
- **Simultaneous events:**
  - Timeout and byte acceptance on the same edge: acceptance wins and the counter clears.
  - Checksum error at `err_cnt==255`: the count stays at 255.

## Configuration

- **`FT_RX_CKSUM_EN` defined:** 5-byte frame; the checksum is checked as described above.
- **`FT_RX_CKSUM_EN` undefined:**
  - 4-byte frame: header, addr, hi, lo.
  - `cmd_valid` is set on the data-low byte.
  - `err_cnt` counts timeouts only.

## Test plan

- **Good frame:** FT model delivers A5 12 34 56 70 with `cmd_ready=1`.
  - OE# low 1 clock after RXF# low; RD# low 1 clock later.
  - `cmd_valid` pulses with `cmd_addr=8'h12`, `cmd_data=16'h3456`; `err_cnt=0`.
- **Bad checksum, then good frame:** A5 12 34 56 71, then A5 01 00 FF FE.
  - First frame is dropped and `err_cnt=1`.
  - Second yields `addr=8'h01`, `data=16'h00FF`.
- **Back-pressure:** two back-to-back frames with `cmd_ready=0` for 50 clocks.
  - Exactly 5 bytes are consumed; RD# stays high while `cmd_valid=1`.
  - The second frame is read only after the handshake.
  - Both commands are delivered in order.
- **Resync and timeout:**
  - Garbage 00 FF A5 12, then RXF# high for `TIMEOUT` clocks: garbage bytes are skipped without error; on timeout `idx→0` and `err_cnt=1`.
  - A following full frame then decodes correctly.
- **Arbitration:** `tx_active_i=1` with RXF# low → OE#/RD# stay high and `ft_bus_busy_o=0`. Dropping `tx_active_i` starts the burst 1 clock later.
- **Reset in mid-frame:** assert `rst` after byte 2 → outputs at reset values asynchronously. After release, a new complete frame decodes and no stale bytes are merged.
